pe_operand_loader: RTL

PE_OPERAND_LOADER -- requirements
Module: pe_operand_loader

---
 rtl/pe_pkg.sv | 18 +
 rtl/pe_nan_detect.sv | 18 +
 rtl/pe_operand_loader.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared float32 field positions and loader FSM encoding for the PE operand loader.
package pe_pkg;

  localparam int FP_W    = 32;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_MSB = 22;
  localparam int MAN_LSB = 0;
  localparam int EXP_W   = EXP_MSB - EXP_LSB + 1;
  localparam int MAN_W   = MAN_MSB - MAN_LSB + 1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } pe_state_e;

endpackage

// File: rtl/pe_nan_detect.sv
// Combinational float32 NaN detector: all-ones exponent with a nonzero mantissa.
module pe_nan_detect
  import pe_pkg::*;
(
  input  logic [FP_W-1:0] din,
  output logic            nan
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             unused_sign;

  assign exp_f       = din[EXP_MSB:EXP_LSB];
  assign man_f       = din[MAN_MSB:MAN_LSB];
  assign unused_sign = din[FP_W-1];
  assign nan         = (&exp_f) && (|man_f);

endmodule

// File: rtl/pe_operand_loader.sv
// Collects N float32 operand pairs for a PE, waits PE_LAT cycles for settling, then holds the result.
// Optional NaN flag on loaded operands is enabled with `define PE_LOADER_NAN_CHECK_EN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
// valid/data may change freely otherwise, and ready does not depend on valid.
module pe_operand_loader
  import pe_pkg::*;
#(
  parameter int N      = 2,
  parameter int PE_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP_W-1:0]   in_a,
  input  logic [FP_W-1:0]   in_b,
  output logic [FP_W*N-1:0] pe_a,
  output logic [FP_W*N-1:0] pe_b,
  input  logic [FP_W-1:0]   pe_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [FP_W-1:0]   res_data,
`ifdef PE_LOADER_NAN_CHECK_EN
  output logic              res_nan,
`endif
  output pe_state_e         dbg_state
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [7:0] CNT_INIT = 8'(PE_LAT - 1);

  pe_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        cnt_q;
  logic [FP_W-1:0]   res_data_q;
  logic [FP_W*N-1:0] pe_a_q, pe_b_q;
  logic              load_fire, last_fire, capture;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    load_fire = 1'b0;
    last_fire = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready  = 1'b1;
        load_fire = in_valid;
        if (in_valid && (idx_q == IDX_LAST)) begin
          last_fire = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 8'd0) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      pe_a_q     <= '0;
      pe_b_q     <= '0;
    end else begin
      state_q <= state_d;
      if (load_fire) begin
        idx_q <= last_fire ? '0 : idx_q + IDX_W'(1);
      end
      // Only the addressed slot changes; the rest keep the previous job's operands.
      for (int k = 0; k < N; k++) begin
        if (load_fire && (idx_q == IDX_W'(k))) begin
          pe_a_q[k*FP_W +: FP_W] <= in_a;
          pe_b_q[k*FP_W +: FP_W] <= in_b;
        end
      end
      if (last_fire) begin
        cnt_q <= CNT_INIT;
      end else if ((state_q == ST_WAIT) && (cnt_q != 8'd0)) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (capture) res_data_q <= pe_result;
    end
  end

`ifdef PE_LOADER_NAN_CHECK_EN
  logic nan_a, nan_b, nan_seen_q;

  pe_nan_detect u_nan_a (.din(in_a), .nan(nan_a));
  pe_nan_detect u_nan_b (.din(in_b), .nan(nan_b));

  // Sticky across the job; cleared when the result is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      nan_seen_q <= 1'b0;
    end else if (load_fire && (nan_a || nan_b)) begin
      nan_seen_q <= 1'b1;
    end else if ((state_q == ST_HOLD) && res_ready) begin
      nan_seen_q <= 1'b0;
    end
  end

  assign res_nan = (state_q == ST_HOLD) && nan_seen_q;
`endif

  assign pe_a      = pe_a_q;
  assign pe_b      = pe_b_q;
  assign res_data  = res_data_q;
  assign dbg_state = state_q;

endmodule
